// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//   Samples an asynchronous periodic input in the clk domain and measures
//   the number of clk cycles between consecutive rising edges. Reports each
//   period, flags too-fast / too-slow periods (sticky), detects loss of the
//   signal and reports lock after a run of in-range periods.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   sig_in     in   asynchronous monitored signal
//   clr        in   clears too_fast / too_slow (a same-cycle set wins)
//   period     out  last measured period in clk cycles
//   period_vld out  one-cycle strobe, period updated
//   too_fast   out  sticky, a period below MIN_PER was seen
//   too_slow   out  sticky, a period above MAX_PER was seen
//   lost       out  level, no rising edge for TIMEOUT cycles
//   locked     out  level, LOCK_CNT consecutive in-range periods seen
module clk_period_monitor #(
    parameter int CNT_W    = 16,
    parameter int MIN_PER  = 8,
    parameter int MAX_PER  = 12,
    parameter int TIMEOUT  = 1000,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             too_fast,
    output logic             too_slow,
    output logic             lost,
    output logic             locked
);

    localparam int LK_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        LOST
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              s1;
    logic              s2;
    logic              s3;
    logic              rise;
    logic [CNT_W-1:0]  cnt;
    logic [LK_W-1:0]   lock_cnt;
    logic              meas_rise;
    logic              timeout_hit;
    logic              in_range;
    logic              set_fast;
    logic              set_slow;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // cnt holds the number of cycles since the last rise (1 in the cycle
    // right after it), so the value seen alongside the next rise is the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        meas_rise   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            MEAS: begin
                // A rise in the timeout cycle is still a valid measurement.
                if (rise) begin
                    meas_rise = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = LOST;
                end
            end
            default: begin
                // IDLE and LOST: the first rise only opens a new interval.
                if (rise) begin
                    state_nxt = MEAS;
                end
            end
        endcase
    end

    always_comb begin
        in_range = (cnt >= CNT_W'(MIN_PER)) && (cnt <= CNT_W'(MAX_PER));
        set_fast = meas_rise && (cnt < CNT_W'(MIN_PER));
        set_slow = meas_rise && (cnt > CNT_W'(MAX_PER));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period     <= '0;
            period_vld <= 1'b0;
            too_fast   <= 1'b0;
            too_slow   <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            period_vld <= meas_rise;
            if (meas_rise) begin
                period <= cnt;
            end
            if (meas_rise) begin
                if (!in_range) begin
                    lock_cnt <= '0;
                end else if (lock_cnt != LK_W'(LOCK_CNT)) begin
                    lock_cnt <= lock_cnt + LK_W'(1);
                end
            end else if (timeout_hit) begin
                lock_cnt <= '0;
            end
            too_fast <= set_fast | (too_fast & ~clr);
            too_slow <= set_slow | (too_slow & ~clr);
        end
    end

    assign lost   = (state == LOST);
    assign locked = (lock_cnt == LK_W'(LOCK_CNT));

endmodule

// File: tb/tb_clk_period_monitor.sv
// Testbench for clk_period_monitor: directed scenarios plus randomized
// waveforms, every cycle compared against a timestamp-based reference model.
module tb_clk_period_monitor;

    localparam int CNT_W    = 16;
    localparam int MIN_PER  = 8;
    localparam int MAX_PER  = 12;
    localparam int TIMEOUT  = 1000;
    localparam int LOCK_CNT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic             clr;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             too_fast;
    logic             too_slow;
    logic             lost;
    logic             locked;

    clk_period_monitor #(
        .CNT_W   (CNT_W),
        .MIN_PER (MIN_PER),
        .MAX_PER (MAX_PER),
        .TIMEOUT (TIMEOUT),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .clr       (clr),
        .period    (period),
        .period_vld(period_vld),
        .too_fast  (too_fast),
        .too_slow  (too_slow),
        .lost      (lost),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: rises are timestamps (edge indices); a period is the
    // difference of two timestamps; loss is TIMEOUT edges since the last one.
    typedef enum {M_IDLE, M_MEAS, M_LOST} mode_t;

    bit          samp[$];
    int          last_rst  = 0;
    int          m_start   = 0;
    int          m_streak  = 0;
    mode_t       m_mode    = M_IDLE;
    int unsigned m_period  = 0;
    bit          m_vld     = 1'b0;
    bit          m_fast    = 1'b0;
    bit          m_slow    = 1'b0;
    int          vld_seen  = 0;

    task automatic model_edge(input bit r, input bit c, input bit s);
        int e;
        int p;
        bit rise;
        bit sf;
        bit ss;
        e = samp.size();
        if (r) begin
            samp.push_back(1'b0);
            last_rst = e;
            m_mode   = M_IDLE;
            m_period = 0;
            m_vld    = 1'b0;
            m_fast   = 1'b0;
            m_slow   = 1'b0;
            m_streak = 0;
            return;
        end
        samp.push_back(s);
        // sig_in seen high at edge k is acted on at edge k+2.
        rise = (e >= last_rst + 2) && samp[e-2] && (e < 3 || !samp[e-3]);
        sf = 1'b0;
        ss = 1'b0;
        m_vld = 1'b0;
        if (rise) begin
            if (m_mode != M_MEAS) begin
                m_mode = M_MEAS;
            end else begin
                p        = e - m_start;
                m_period = p;
                m_vld    = 1'b1;
                sf       = (p < MIN_PER);
                ss       = (p > MAX_PER);
                if (sf || ss) m_streak = 0;
                else if (m_streak < LOCK_CNT) m_streak++;
            end
            m_start = e;
        end else if (m_mode == M_MEAS && (e - m_start) == TIMEOUT) begin
            m_mode   = M_LOST;
            m_streak = 0;
        end
        m_fast = sf | (m_fast & !c);
        m_slow = ss | (m_slow & !c);
    endtask

    task automatic step(input bit r, input bit c, input bit s);
        rst    = r;
        clr    = c;
        sig_in = s;
        model_edge(r, c, s);
        @(posedge clk);
        #1;
        check("period", period, m_period);
        check("period_vld", period_vld, m_vld);
        check("too_fast", too_fast, m_fast);
        check("too_slow", too_slow, m_slow);
        check("lost", lost, m_mode == M_LOST);
        check("locked", locked, m_streak == LOCK_CNT);
        if (period_vld === 1'b1) vld_seen++;
    endtask

    // n periods of per cycles, hi cycles high; clr is raised in period
    // clr_per at the edge where that period's rise is acted on.
    task automatic wave(input int unsigned per, input int unsigned hi,
                        input int unsigned n, input int unsigned clr_per);
        for (int unsigned k = 0; k < n; k++) begin
            for (int unsigned i = 0; i < per; i++) begin
                step(1'b0, (k == clr_per) && (i == 2), i < hi);
            end
        end
    endtask

    localparam int unsigned NO_CLR = 999;

    initial begin
        int vs;
        int unsigned per;
        int unsigned hi;
        int unsigned n;

        // Reset for 3 cycles with sig_in toggling.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        vld_seen = 0;
        wave(10, 5, 1, NO_CLR);
        check("t1_first_rise_no_vld", vld_seen, 0);

        // Steady period 10.
        wave(10, 5, 6, NO_CLR);
        check("t2_vld_count", vld_seen, 6);
        check("t2_period", period, 10);
        check("t2_locked", locked, 1);
        check("t2_flags", {too_fast, too_slow}, 0);

        // Too fast, clear, too slow, relock.
        wave(6, 3, 3, NO_CLR);
        check("t3_period6", period, 6);
        check("t3_fast", too_fast, 1);
        check("t3_unlocked", locked, 0);
        step(1'b0, 1'b1, 1'b0);
        check("t3_clr", too_fast, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        wave(14, 7, 2, NO_CLR);
        check("t3_slow", too_slow, 1);
        wave(10, 5, 5, NO_CLR);
        check("t3_relock", locked, 1);

        // Loss and recovery.
        repeat (1005) step(1'b0, 1'b0, 1'b0);
        check("t4_lost", lost, 1);
        check("t4_unlocked", locked, 0);
        vs = vld_seen;
        wave(10, 5, 1, NO_CLR);
        check("t4_recover", lost, 0);
        check("t4_no_vld", vld_seen - vs, 0);
        wave(10, 5, 1, NO_CLR);
        check("t4_period", period, 10);

        // clr in the same cycle as an out-of-range period.
        wave(10, 5, 2, NO_CLR);
        check("t5_pre", too_fast, 0);
        wave(6, 3, 2, 1);
        check("t5_set_wins", too_fast, 1);

        // Reset mid-period with sig_in high.
        wave(10, 5, 5, NO_CLR);
        check("t6_pre_locked", locked, 1);
        repeat (4) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("t6_period", period, 0);
        check("t6_flags", {too_fast, too_slow, locked, lost}, 0);
        vs = vld_seen;
        repeat (5) step(1'b0, 1'b0, 1'b0);
        wave(10, 5, 1, NO_CLR);
        check("t6_no_early_vld", vld_seen - vs, 0);
        wave(10, 5, 1, NO_CLR);
        check("t6_second_rise_vld", vld_seen - vs, 1);
        check("t6_period", period, 10);

        // Rise exactly at the timeout count: reported, not lost.
        wave(1000, 5, 2, NO_CLR);
        check("tie_period", period, TIMEOUT);
        check("tie_not_lost", lost, 0);
        check("tie_slow", too_slow, 1);

        // Randomized periods, duty cycles, clr pulses and resets.
        repeat (60) begin
            per = $urandom_range(4, 16);
            hi  = $urandom_range(1, per - 1);
            n   = $urandom_range(1, 4);
            for (int unsigned k = 0; k < n; k++) begin
                for (int unsigned i = 0; i < per; i++) begin
                    step($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0, i < hi);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
